// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter.
// Frame on the line: one start bit (0), DATA_BITS data bits LSB first,
// then two stop bits (1).
// Optional build macro UART_TX_PARITY_EN: the top data bit carries the even
// parity of the lower DATA_BITS-1 bits. The parity is computed when the word
// is accepted.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 500,
  parameter int DATA_BITS    = 9
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Data,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done,
  output logic [2:0]           o_SM_Main,
  output logic [3:0]           o_Bit_Index
);

  // A one-cycle bit time still needs a 1-bit counter.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       IDX_LAST = 4'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE     = 3'b010;
  localparam logic [2:0] S_START    = 3'b001;
  localparam logic [2:0] S_DATA     = 3'b111;
  localparam logic [2:0] S_STOP1    = 3'b100;
  localparam logic [2:0] S_STOP2    = 3'b101;
  localparam logic [2:0] S_CLEANUP  = 3'b110;

`ifdef UART_TX_PARITY_EN
  // Even parity over the payload bits below the top bit.
  function automatic logic even_parity(input logic [DATA_BITS-2:0] w);
    return ^w;
  endfunction

  // The top bit of the latched word is replaced by the parity.
  function automatic logic [DATA_BITS-1:0] load_word(input logic [DATA_BITS-1:0] w);
    return {even_parity(w[DATA_BITS-2:0]), w[DATA_BITS-2:0]};
  endfunction
`else
  // The word is sent exactly as it was presented.
  function automatic logic [DATA_BITS-1:0] load_word(input logic [DATA_BITS-1:0] w);
    return w;
  endfunction
`endif

  logic [2:0]           state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [3:0]           idx_q,    idx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q,   done_d;
  logic                 bit_end_s;

  assign bit_end_s = (cnt_q == CNT_LAST);

  // Next-state logic: bit timing, data bit sequencing and word capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        idx_d = 4'd0;
        if (i_TX_DV) begin
          shift_d = load_word(i_TX_Data);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          cnt_d   = CNT_ZERO;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (idx_q < IDX_LAST) begin
            idx_d = idx_q + 4'd1;
          end else begin
            idx_d   = 4'd0;
            state_d = S_STOP1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP1: begin
        if (bit_end_s) begin
          cnt_d   = CNT_ZERO;
          state_d = S_STOP2;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP2: begin
        if (bit_end_s) begin
          cnt_d   = CNT_ZERO;
          done_d  = 1'b1;
          state_d = S_CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CLEANUP: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = CNT_ZERO;
        idx_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line and busy values follow the state being entered, so that the
  // registered outputs line up with it.
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    case (state_d)
      S_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      S_DATA: begin
        serial_d = shift_d[idx_d];
        active_d = 1'b1;
      end
      S_STOP1, S_STOP2: begin
        serial_d = 1'b1;
        active_d = 1'b1;
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset drives the line high at once.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      idx_q    <= 4'd0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;
  assign o_SM_Main   = state_q;
  assign o_Bit_Index = idx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame with CLKS_PER_BIT=4 and DATA_BITS=9.
// The expected line waveform comes from the frame rules: start 0, data LSB first, then 1,1.
module tb_uart_tx_frame;
  localparam int CPB   = 4;
  localparam int DB    = 9;
  localparam int FRAME = (3 + DB) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dv = 1'b0;
  logic [DB-1:0] data = '0;
  logic          o_TX_Serial, o_TX_Active, o_TX_Done;
  logic [2:0]    o_SM_Main;
  logic [3:0]    o_Bit_Index;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DB-1:0] din;
    logic [DB-1:0] word;
  } vec_t;
  vec_t vecs[4];

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_TX_DV    (dv),
    .i_TX_Data  (data),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Active(o_TX_Active),
    .o_TX_Done  (o_TX_Done),
    .o_SM_Main  (o_SM_Main),
    .o_Bit_Index(o_Bit_Index)
  );

  always #5 clk = ~clk;

  // Reference: the word that should appear on the line for a given input.
  function automatic logic [DB-1:0] expected_word(input logic [DB-1:0] d);
    logic [DB-1:0] w;
    w = d;
`ifdef UART_TX_PARITY_EN
    begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < DB - 1; i++) p = p ^ d[i];
      w[DB-1] = p;
    end
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_serial_c%0d", tag, i), 16'(o_TX_Serial), 16'd1);
      chk($sformatf("%s_active_c%0d", tag, i), 16'(o_TX_Active), 16'd0);
      chk($sformatf("%s_done_c%0d", tag, i),   16'(o_TX_Done),   16'd0);
      chk($sformatf("%s_state_c%0d", tag, i),  16'(o_SM_Main),   16'h2);
      step();
    end
  endtask

  // Starts at the sample just after the accept edge. Ends one cycle after the done pulse.
  task automatic check_frame(input logic [DB-1:0] word, input int inject_at, input string tag);
    logic [11:0] frame;
    frame = {2'b11, word, 1'b0};
    for (int s = 0; s < FRAME; s++) begin
      int seg;
      logic [2:0] st;
      logic [3:0] ix;
      seg = s / CPB;
      if (seg == 0) st = 3'b001;
      else if (seg <= DB) st = 3'b111;
      else if (seg == DB + 1) st = 3'b100;
      else st = 3'b101;
      ix = (seg >= 1 && seg <= DB) ? 4'(seg - 1) : 4'd0;
      chk($sformatf("%s_serial_s%0d", tag, s), 16'(o_TX_Serial), 16'(frame[seg]));
      chk($sformatf("%s_active_s%0d", tag, s), 16'(o_TX_Active), 16'd1);
      chk($sformatf("%s_done_s%0d", tag, s),   16'(o_TX_Done),   16'd0);
      chk($sformatf("%s_state_s%0d", tag, s),  16'(o_SM_Main),   16'(st));
      chk($sformatf("%s_index_s%0d", tag, s),  16'(o_Bit_Index), 16'(ix));
      if (s == inject_at) begin
        dv   = 1'b1;
        data = 9'h1FF;
      end
      step();
      if (s == inject_at) dv = 1'b0;
    end
    chk({tag, "_done_pulse"},    16'(o_TX_Done),   16'd1);
    chk({tag, "_active_end"},    16'(o_TX_Active), 16'd0);
    chk({tag, "_serial_end"},    16'(o_TX_Serial), 16'd1);
    chk({tag, "_state_cleanup"}, 16'(o_SM_Main),   16'h6);
    step();
    chk({tag, "_done_clear"},    16'(o_TX_Done),   16'd0);
    chk({tag, "_serial_gap"},    16'(o_TX_Serial), 16'd1);
    chk({tag, "_state_idle"},    16'(o_SM_Main),   16'h2);
  endtask

  task automatic send(input logic [DB-1:0] din, input logic [DB-1:0] word,
                      input int inject_at, input string tag);
    dv   = 1'b1;
    data = din;
    step();
    dv   = 1'b0;
    data = DB'($urandom);
    check_frame(word, inject_at, tag);
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{9'h007, 9'h107};
    vecs[1] = '{9'h003, 9'h003};
    vecs[2] = '{9'h0A5, 9'h0A5};
    vecs[3] = '{9'h1FF, 9'h0FF};
`else
    vecs[0] = '{9'h0A5, 9'h0A5};
    vecs[1] = '{9'h1FF, 9'h1FF};
    vecs[2] = '{9'h103, 9'h103};
    vecs[3] = '{9'h0AA, 9'h0AA};
`endif

    // Reset held for 5 cycles, then 100 idle cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_serial", 16'(o_TX_Serial), 16'd1);
      chk("rst_active", 16'(o_TX_Active), 16'd0);
      chk("rst_done",   16'(o_TX_Done),   16'd0);
      chk("rst_state",  16'(o_SM_Main),   16'h2);
      chk("rst_index",  16'(o_Bit_Index), 16'd0);
    end
    rst_n = 1'b1;
    idle_check(100, "idle");

    // Directed frames from the table.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].din, vecs[i].word, -1, $sformatf("vec%0d", i));
      idle_check(3, $sformatf("vec%0d_after", i));
    end

    // A request while busy is ignored.
    send(9'h000, expected_word(9'h000), 10, "busy");
    idle_check(20, "busy_after");

    // Back-to-back frames with the request held high.
    dv   = 1'b1;
    data = 9'h155;
    step();
    check_frame(expected_word(9'h155), -1, "b2b0");
    data = 9'h0AA;
    step();
    dv = 1'b0;
    check_frame(expected_word(9'h0AA), -1, "b2b1");
    idle_check(10, "b2b_after");

    // Reset asserted while data bit 3 is on the line.
    dv   = 1'b1;
    data = 9'h0F7;
    step();
    dv = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("mrst_pre_serial", 16'(o_TX_Serial), 16'd0);
    chk("mrst_pre_index",  16'(o_Bit_Index), 16'd3);
    chk("mrst_pre_state",  16'(o_SM_Main),   16'h7);
    rst_n = 1'b0;
    #1;
    chk("mrst_serial", 16'(o_TX_Serial), 16'd1);
    chk("mrst_active", 16'(o_TX_Active), 16'd0);
    chk("mrst_done",   16'(o_TX_Done),   16'd0);
    chk("mrst_state",  16'(o_SM_Main),   16'h2);
    chk("mrst_index",  16'(o_Bit_Index), 16'd0);
    step();
    step();
    rst_n = 1'b1;
    idle_check(60, "mrst_after");

    // Random words with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      logic [DB-1:0] d;
      d = DB'($urandom);
      send(d, expected_word(d), -1, $sformatf("rnd%0d", i));
      idle_check(int'($urandom_range(0, 3)), $sformatf("rnd%0d_gap", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmitter for the board's UART link. It produces the frame format that our receiver expects: 1 start bit (0), DATA_BITS data bits sent LSB first, then 2 stop bits (1).
- Sits between the host-side control logic and the TX pin.
- Accepts one word per handshake and reports busy/done status plus debug state outputs.

Parameters:
- CLKS_PER_BIT, 500, clock cycles per bit = f(i_Clock)/baud (50 MHz / 100 kbaud)
- DATA_BITS, 9, bits per frame between start and stop; legal range 5..15

Ports:
- i_Clock  in  1  system clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_TX_DV  in  1  one-cycle request: load i_TX_Data and start a frame
- i_TX_Data  in  DATA_BITS  word to send; bit 0 goes out first
- o_TX_Serial  out  1  serial line, idles high
- o_TX_Active  out  1  high while a frame is on the line
- o_TX_Done  out  1  one-cycle pulse after the second stop bit completes
- o_SM_Main  out  3  current state encoding (debug)
- o_Bit_Index  out  4  index of the data bit being sent (debug)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; o_TX_Serial=1; o_TX_Active=0; o_TX_Done=0.
  - Clock counter, bit index and shift register all cleared to 0.
- State encodings: IDLE=3'b010, TX_START_BIT=3'b001, TX_DATA_BITS=3'b111, TX_STOP_BIT_1=3'b100, TX_STOP_BIT_2=3'b101, CLEANUP=3'b110. Any other value returns to IDLE on the next clock.
- Clock counter is $clog2(CLKS_PER_BIT) bits wide and never overflows. Bit index is 4 bits.
- IDLE:
  - o_TX_Serial=1, o_TX_Active=0, counter=0, index=0.
  - If i_TX_DV=1: latch i_TX_Data into the shift register, set o_TX_Active=1, go to TX_START_BIT.
- TX_START_BIT:
  - Drive 0 for exactly CLKS_PER_BIT cycles (counter 0..CLKS_PER_BIT-1).
  - At count CLKS_PER_BIT-1: clear counter, go to TX_DATA_BITS.
- TX_DATA_BITS:
  - Drive shift_reg[index] for CLKS_PER_BIT cycles.
  - At the end of each bit, clear counter. If index<DATA_BITS-1, increment index; otherwise set index=0 and go to TX_STOP_BIT_1.
- TX_STOP_BIT_1 and TX_STOP_BIT_2: each drives 1 for CLKS_PER_BIT cycles.
- At the end of TX_STOP_BIT_2: o_TX_Done=1, o_TX_Active=0, go to CLEANUP.
- CLEANUP: lasts one cycle; o_TX_Serial=1, o_TX_Done is deasserted at the next edge, then go to IDLE.
- Output timing:
  - o_TX_Serial is registered and falls 1 cycle after the i_TX_DV accept edge.
  - Frame length on the line is (3+DATA_BITS)*CLKS_PER_BIT cycles: 6000 with defaults.
- i_TX_DV is ignored outside IDLE. No queuing, and the latched data is unaffected by input changes mid-frame.
- Back-to-back: i_TX_DV held high continuously gives 2 extra idle-high cycles (CLEANUP + IDLE) between the end of stop bit 2 and the next start bit.
- Reset asserted mid-frame: the line returns high immediately (async) and no o_TX_Done pulse is issued.
- CLKS_PER_BIT=1 is legal: each bit lasts one cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: bit DATA_BITS-1 of the latched word is replaced by even parity, i.e. the XOR of i_TX_Data[DATA_BITS-2:0], computed at accept. With the default this gives 8 data bits + parity, matching the receiver's 9-bit capture.
- Undefined: all DATA_BITS bits are sent verbatim from i_TX_Data.
- Frame timing is identical in both builds.

Test Plan:
- Reset and idle: hold i_Reset_n=0 for 5 cycles, then release with i_TX_DV=0 for 100 cycles -> o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_SM_Main=3'b010 throughout.
- Single frame, CLKS_PER_BIT=4, DATA_BITS=9, data 9'h0A5:
  - line shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1,0 at 4 cycles each, then 1 for 8 cycles;
  - o_TX_Done pulses exactly once, 48 cycles after the line falls.
- Busy ignore: pulse i_TX_DV with 9'h1FF at cycle 10 of a 9'h000 frame -> the frame still carries all-zero data and no second frame follows.
- Back-to-back: hold i_TX_DV=1 with 9'h155 then 9'h0AA -> two correct frames separated by exactly 2 high cycles after stop bit 2.
- Mid-frame reset: assert i_Reset_n=0 during TX_DATA_BITS index 3 -> o_TX_Serial=1 within the same cycle, and o_TX_Done never pulses.
- UART_TX_PARITY_EN defined, data 9'h007 -> bit 8 on the line = 1; data 9'h003 -> bit 8 = 0.
